// File: rtl/master_req_sequencer.sv
// Upstream request feeder for the 3-master bus arbiter: turns per-master starts and
// beat lengths into one-cycle req/done pulses and re-requests after lost or missed grants.
module master_req_sequencer #(
  parameter int LEN_W        = 4,
  parameter int WAIT_TIMEOUT = 8,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           start,
  input  logic [3*LEN_W-1:0]   len,
  input  logic [1:0]           accmodule,
  output logic [2:0]           req,
  output logic [2:0]           done,
  output logic [2:0]           busy,
  output logic [2:0]           spurious_grant,
  output logic [CNT_W-1:0]     regrant_cnt
);

  localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int CW1   = CNT_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_XFER, S_DONE} state_t;

  state_t             r_state [3];
  logic [LEN_W-1:0]   r_len   [3];
  logic [LEN_W-1:0]   r_beat  [3];
  logic [TMO_W-1:0]   r_tmo   [3];
  logic [2:0]         r_req;
  logic [2:0]         r_done;
  logic [2:0]         r_busy;
  logic [2:0]         r_spur;
  logic [CNT_W-1:0]   r_cnt;

  logic [2:0]         w_grant;
  logic [2:0]         w_rereq;
  logic [1:0]         w_rereq_n;
  logic [CNT_W:0]     w_cnt_sum;

  // A channel re-requests when it loses the grant mid-transfer or its wait times out.
  always_comb begin
    w_grant = '0;
    w_rereq = '0;
    for (int c = 0; c < 3; c++) begin
      w_grant[c] = (accmodule == 2'(c + 1));
      w_rereq[c] = !w_grant[c] &&
                   ((r_state[c] == S_XFER) ||
                    (r_state[c] == S_WAIT && r_tmo[c] == TMO_W'(WAIT_TIMEOUT - 1)));
    end
    w_rereq_n = 2'(w_rereq[0]) + 2'(w_rereq[1]) + 2'(w_rereq[2]);
    w_cnt_sum = {1'b0, r_cnt} + CW1'(w_rereq_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        r_state[c] <= S_IDLE;
        r_len[c]   <= '0;
        r_beat[c]  <= '0;
        r_tmo[c]   <= '0;
      end
      r_req  <= '0;
      r_done <= '0;
      r_busy <= '0;
      r_spur <= '0;
      r_cnt  <= '0;
    end else begin
      r_req  <= '0;
      r_done <= '0;
      for (int c = 0; c < 3; c++) begin
        r_spur[c] <= w_grant[c] && (r_state[c] == S_IDLE || r_state[c] == S_REQ);
        case (r_state[c])
          S_IDLE: begin
            if (start[c]) begin
              r_len[c]   <= (len[c*LEN_W +: LEN_W] == '0) ? LEN_W'(1) : len[c*LEN_W +: LEN_W];
              r_beat[c]  <= '0;
              r_state[c] <= S_REQ;
              r_req[c]   <= 1'b1;
              r_busy[c]  <= 1'b1;
            end
          end
          S_REQ: begin
            r_state[c] <= S_WAIT;
            r_tmo[c]   <= '0;
          end
          // The beat counter stops at len, so it can never wrap even for len = 2^LEN_W-1.
          S_WAIT, S_XFER: begin
            if (w_grant[c]) begin
              r_beat[c] <= r_beat[c] + LEN_W'(1);
              r_tmo[c]  <= '0;
              if (r_beat[c] + LEN_W'(1) == r_len[c]) begin
                r_state[c] <= S_DONE;
                r_done[c]  <= 1'b1;
              end else begin
                r_state[c] <= S_XFER;
              end
            end else if (w_rereq[c]) begin
              r_state[c] <= S_REQ;
              r_req[c]   <= 1'b1;
            end else begin
              r_tmo[c] <= r_tmo[c] + TMO_W'(1);
            end
          end
          S_DONE: begin
            r_state[c] <= S_IDLE;
            r_busy[c]  <= 1'b0;
          end
          default: r_state[c] <= S_IDLE;
        endcase
      end
      r_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign req            = r_req;
  assign done           = r_done;
  assign busy           = r_busy;
  assign spurious_grant = r_spur;
  assign regrant_cnt    = r_cnt;

endmodule

// File: tb/tb_master_req_sequencer.sv
// Bench for master_req_sequencer: directed vector table, corner-case sequences,
// and random traffic checked against a transaction-level reference model.
module tb_master_req_sequencer;

  localparam int LEN_W        = 4;
  localparam int WAIT_TIMEOUT = 8;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [2:0]           start;
  logic [3*LEN_W-1:0]   len;
  logic [1:0]           accmodule;
  logic [2:0]           req, done, busy, spurious_grant;
  logic [CNT_W-1:0]     regrant_cnt;

  master_req_sequencer #(.LEN_W(LEN_W), .WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .accmodule(accmodule),
    .req(req), .done(done), .busy(busy), .spurious_grant(spurious_grant),
    .regrant_cnt(regrant_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_model = 1'b0;

  // Reference model: each channel is "busy" with some beats left; pending pulses are
  // flags that the next edge consumes.
  bit m_busy [3], m_req [3], m_done [3], m_spur [3], m_holding [3];
  int m_left [3], m_waited [3], m_cnt;

  int n_req [3], n_done [3], t_done [3];

  typedef struct {
    logic [2:0]  st;
    logic [11:0] ln;
    logic [1:0]  ac;
    logic [2:0]  e_req, e_done, e_busy, e_spur;
  } vec_t;
  vec_t tbl [11];

  function automatic vec_t mk(logic [2:0] st, logic [11:0] ln, logic [1:0] ac,
                              logic [2:0] er, logic [2:0] ed, logic [2:0] eb, logic [2:0] es);
    vec_t v;
    v.st = st; v.ln = ln; v.ac = ac;
    v.e_req = er; v.e_done = ed; v.e_busy = eb; v.e_spur = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_busy[c] = 0; m_req[c] = 0; m_done[c] = 0; m_spur[c] = 0; m_holding[c] = 0;
      m_left[c] = 0; m_waited[c] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step();
    int n;
    bit g;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      g = (int'(accmodule) == c + 1);
      m_spur[c] = 0;
      if (!m_busy[c]) begin
        m_spur[c] = g;
        if (start[c]) begin
          m_busy[c] = 1;
          m_left[c] = int'(len[c*LEN_W +: LEN_W]);
          if (m_left[c] == 0) m_left[c] = 1;
          m_req[c] = 1;
        end
      end else if (m_done[c]) begin
        m_done[c] = 0;
        m_busy[c] = 0;
      end else if (m_req[c]) begin
        m_req[c] = 0;
        m_spur[c] = g;
        m_waited[c] = 0;
        m_holding[c] = 0;
      end else if (g) begin
        m_left[c]--;
        m_waited[c] = 0;
        m_holding[c] = 1;
        if (m_left[c] == 0) m_done[c] = 1;
      end else if (m_holding[c]) begin
        m_holding[c] = 0;
        m_req[c] = 1;
        n++;
      end else begin
        m_waited[c]++;
        if (m_waited[c] == WAIT_TIMEOUT) begin
          m_req[c] = 1;
          n++;
        end
      end
    end
    m_cnt = (m_cnt + n > CNT_MAX) ? CNT_MAX : m_cnt + n;
  endtask

  task automatic compare_model();
    logic [2:0] er, ed, eb, es;
    for (int c = 0; c < 3; c++) begin
      er[c] = m_req[c]; ed[c] = m_done[c]; eb[c] = m_busy[c]; es[c] = m_spur[c];
    end
    chk("req", req, er);
    chk("done", done, ed);
    chk("busy", busy, eb);
    chk("spurious_grant", spurious_grant, es);
    chk("regrant_cnt", regrant_cnt, m_cnt);
    chk("req_and_done", req & done, 0);
  endtask

  task automatic clr_counts();
    for (int c = 0; c < 3; c++) begin
      n_req[c] = 0; n_done[c] = 0; t_done[c] = -1;
    end
  endtask

  // Called at a negedge: drive inputs, let one edge pass, observe at the next negedge.
  task automatic step(input logic [2:0] s, input logic [11:0] l, input logic [1:0] a);
    start = s; len = l; accmodule = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 3; c++) begin
      if (req[c]) n_req[c]++;
      if (done[c]) begin
        n_done[c]++;
        if (t_done[c] < 0) t_done[c] = cyc;
      end
    end
    if (cmp_model) compare_model();
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spur", spurious_grant, 0);
    chk("rst_cnt", regrant_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] a;
    logic [2:0] s;
    reset = 1'b0; start = '0; len = '0; accmodule = '0;
    model_reset();
    clr_counts();
    repeat (2) @(negedge clk);
    chk("reset_req", req, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_spur", spurious_grant, 0);
    chk("reset_cnt", regrant_cnt, 0);
    reset = 1'b1;

    // M2 len=2, spurious grant to idle M2, M1 with len=0
    tbl[0]  = mk(3'b010, 12'h020, 2'b00, 3'b010, 3'b000, 3'b010, 3'b000);
    tbl[1]  = mk(3'b000, 12'h000, 2'b00, 3'b000, 3'b000, 3'b010, 3'b000);
    tbl[2]  = mk(3'b000, 12'h000, 2'b10, 3'b000, 3'b000, 3'b010, 3'b000);
    tbl[3]  = mk(3'b000, 12'h000, 2'b10, 3'b000, 3'b010, 3'b010, 3'b000);
    tbl[4]  = mk(3'b000, 12'h000, 2'b00, 3'b000, 3'b000, 3'b000, 3'b000);
    tbl[5]  = mk(3'b000, 12'h000, 2'b10, 3'b000, 3'b000, 3'b000, 3'b010);
    tbl[6]  = mk(3'b000, 12'h000, 2'b00, 3'b000, 3'b000, 3'b000, 3'b000);
    tbl[7]  = mk(3'b001, 12'h000, 2'b00, 3'b001, 3'b000, 3'b001, 3'b000);
    tbl[8]  = mk(3'b000, 12'h000, 2'b00, 3'b000, 3'b000, 3'b001, 3'b000);
    tbl[9]  = mk(3'b000, 12'h000, 2'b01, 3'b000, 3'b001, 3'b001, 3'b000);
    tbl[10] = mk(3'b000, 12'h000, 2'b00, 3'b000, 3'b000, 3'b000, 3'b000);
    for (int j = 0; j < 11; j++) begin
      step(tbl[j].st, tbl[j].ln, tbl[j].ac);
      chk($sformatf("tbl%0d_req", j), req, tbl[j].e_req);
      chk($sformatf("tbl%0d_done", j), done, tbl[j].e_done);
      chk($sformatf("tbl%0d_busy", j), busy, tbl[j].e_busy);
      chk($sformatf("tbl%0d_spur", j), spurious_grant, tbl[j].e_spur);
      chk($sformatf("tbl%0d_cnt", j), regrant_cnt, 0);
    end
    cmp_model = 1'b1;

    // M2 len=4 interrupted by M1 after two beats
    clr_counts();
    step(3'b010, 12'h040, 2'b00);
    step(3'b000, 12'h000, 2'b00);
    step(3'b000, 12'h000, 2'b10);
    step(3'b000, 12'h000, 2'b10);
    step(3'b000, 12'h000, 2'b01);
    step(3'b000, 12'h000, 2'b01);
    step(3'b000, 12'h000, 2'b10);
    step(3'b000, 12'h000, 2'b10);
    step(3'b000, 12'h000, 2'b00);
    chk("intr_req_pulses", n_req[1], 2);
    chk("intr_done_pulses", n_done[1], 1);
    chk("intr_regrant", regrant_cnt, 1);
    chk("intr_idle", busy, 0);

    // M3 never granted: re-request every WAIT_TIMEOUT+1 cycles
    clr_counts();
    step(3'b100, 12'h100, 2'b00);
    for (int k = 0; k < 3 * (WAIT_TIMEOUT + 1); k++) step(3'b000, 12'h000, 2'b00);
    chk("tmo_req_pulses", n_req[2], 4);
    chk("tmo_no_done", n_done[2], 0);
    chk("tmo_regrant", regrant_cnt, 4);
    step(3'b000, 12'h000, 2'b00);
    step(3'b000, 12'h000, 2'b11);
    step(3'b000, 12'h000, 2'b00);
    chk("tmo_finish_done", n_done[2], 1);

    // M1 and M3 together, arbiter serves M1 first
    clr_counts();
    step(3'b101, 12'h101, 2'b00);
    chk("pair_req", req, 3'b101);
    step(3'b000, 12'h000, 2'b00);
    step(3'b000, 12'h000, 2'b01);
    step(3'b000, 12'h000, 2'b11);
    step(3'b000, 12'h000, 2'b00);
    chk("pair_done0", n_done[0], 1);
    chk("pair_done2", n_done[2], 1);
    chk("pair_order", (t_done[0] >= 0) && (t_done[0] < t_done[2]), 1);

    // Reset in the middle of an M2 transfer
    clr_counts();
    step(3'b010, 12'h050, 2'b00);
    step(3'b000, 12'h000, 2'b00);
    step(3'b000, 12'h000, 2'b10);
    step(3'b000, 12'h000, 2'b10);
    async_reset();
    for (int k = 0; k < 4; k++) step(3'b000, 12'h000, 2'b10);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", n_done[1], 0);

    // All three waiting forever: counter takes +3 per timeout and saturates
    step(3'b111, 12'h111, 2'b00);
    for (int k = 0; k < 900; k++) step(3'b000, 12'h000, 2'b00);
    chk("sat_cnt", regrant_cnt, CNT_MAX);

    // Random traffic against the model
    async_reset();
    a = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      s = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 1) == 0) a = 2'($urandom);
      step(s, 12'($urandom), a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/master_req_sequencer.md
Name: master_req_sequencer

Overview:
- Upstream feeder for the 3-master bus arbiter (M1 priority/interrupting, M2, M3).
- Converts per-master transaction starts plus beat lengths into the arbiter's one-cycle req/done pulses and tracks granted beats via accmodule.
- Re-requests after grant loss (M1 interrupt, 2-cycle access limit) or a missed request.
- By construction, req and done are never held more than 1 cycle and never asserted together on the same master.

Parameters:
LEN_W, 4, width of the per-master beat length.
WAIT_TIMEOUT, 8, cycles spent in WAIT without grant before req is re-pulsed.
CNT_W, 8, width of the saturating re-request counter.

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset
start  input  3  bit i: master i requests a transaction; sampled only in IDLE
len  input  3*LEN_W  master i length at [i*LEN_W +: LEN_W]; latched with start
accmodule  input  2  arbiter grant: 00 none, 01 M1, 10 M2, 11 M3
req  output  3  one-cycle request pulses to arbiter
done  output  3  one-cycle completion pulses to arbiter
busy  output  3  bit i high while channel i is not IDLE
spurious_grant  output  3  one-cycle flag: grant to channel i while IDLE or REQ
regrant_cnt  output  CNT_W  total re-requests over all channels, saturating

Behaviour:
- Reset (reset==0, async):
  - All channels IDLE.
  - req, done, busy, spurious_grant = 0; regrant_cnt = 0.
  - Beat and timeout counters = 0.
  - Mid-transaction reset abandons the transaction; no done is issued.
- Three independent identical channel FSMs. Channel i's grant code is i+1. All outputs are registered.
- Per-channel FSM states:
  - IDLE:
    - On start[i] at an edge: latch len; len==0 is treated as 1. Clear beat count; go to REQ.
  - REQ:
    - req[i]=1 for exactly this cycle.
    - Next state is WAIT unconditionally.
  - WAIT:
    - req low. Timeout counter increments every cycle.
    - If accmodule==code at an edge: count a beat, clear the timeout, go to XFER. If that beat is the final one, go to DONE instead.
    - If the timeout reaches WAIT_TIMEOUT: go to REQ and increment regrant_cnt.
  - XFER:
    - Each edge with accmodule==code counts one beat.
    - When the beat count equals len: go to DONE.
    - If accmodule!=code at an edge before the final beat: grant is lost. The beat count is held; go to REQ and increment regrant_cnt.
    - REQ after WAIT/XFER always follows at least one cycle with req low, so req never sees back-to-back pulses.
  - DONE:
    - done[i]=1 for exactly this cycle. Grant during DONE is not a beat.
    - Next state is IDLE. start is ignored in this cycle.
    - IDLE->REQ takes a further edge, so done and the next req are never adjacent.
- Latency example: start sampled at edge k gives req high in cycle k+1, grant in cycle k+2 (first beat at end of k+2). With len=2, done is high in cycle k+4.
- Boundary cases:
  - Final beat and grant loss in the same edge: the beat counts only if accmodule==code at that edge.
  - Grant observed while IDLE or REQ: spurious_grant[i] pulses 1 cycle; it is not counted as a beat.
  - Multiple channels starting in the same cycle: each pulses req in the same cycle. The arbiter resolves priority.
  - regrant_cnt saturates at 2^CNT_W-1. If several channels re-request at one edge, it adds the number of channels.
  - len max is 2^LEN_W-1. The beat counter must not wrap.

Test Plan:
- M2 start, len=2, arbiter grants cycles k+2..k+3 -> req[1] high in k+1 only, done[1] high in k+4 only, busy[1] low from k+5, regrant_cnt=0.
- M2 len=4; M1 interrupts after 2 beats (accmodule=01 for 2 cycles) -> M2 goes to REQ; req[1] re-pulsed, regrant_cnt=1; 2 more granted beats then done[1]; total granted-and-counted beats = 4.
- M3 start, accmodule held 00 -> req[2] pulses every WAIT_TIMEOUT+1 cycles (9 with default); regrant_cnt increments each time; no done.
- M1 and M3 start same cycle, len=1 each; arbiter serves M1 then M3 -> both req pulse together; done[0] before done[2]; never req[i]&done[i].
- M2 mid-XFER, reset driven low asynchronously between edges -> all outputs 0 immediately, no done; after release busy=0 until next start.
- len=0 on M1 -> behaves as len=1: single granted beat then done[0].
- Grant of 10 while M2 is IDLE -> spurious_grant[1]=1 for one cycle, M2 stays IDLE.
